keypad_scanner: RTL

//  Input-side counterpart of the seven-segment scan driver. Drives an active-low one-hot row strobe

---
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-strobed key-matrix scanner with frame debounce and a one-entry key-code holding register.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV_W     = 10,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_FRAMES  = 64
) (
   input  logic            clock,
   input  logic            reset,
   output logic [ROWS-1:0] row_sel,
   input  logic [COLS-1:0] col_in,
   output logic [15:0]     key_code,
   output logic            key_valid,
   input  logic            key_ack,
   output logic            overflow
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SCAN_DIV_W-1:0] DIV_LAST = '1;

   if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || SCAN_DIV_W < 1 ||
       DEBOUNCE_SCANS < 2 || REPEAT_FRAMES < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PRESS_DB = 2'd1,
      S_HELD     = 2'd2,
      S_REL_DB   = 2'd3
   } state_t;

   logic                       r_scan_en;
   logic [SCAN_DIV_W-1:0]      r_div;
   logic [ROW_W-1:0]           r_row;
   logic [ROWS-1:0][COLS-1:0]  r_snap;
   logic                       r_frame_done;
   logic                       w_last_dwell;

   state_t                     r_state, w_state_nxt;
   logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
   logic [7:0]                 r_cand, w_cand_nxt;
   logic                       w_emit;

   logic                       w_any, w_multi, w_single;
   logic [7:0]                 w_key;

   logic [7:0]                 r_code;
   logic                       r_valid;
   logic                       r_ovf;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
   logic [REP_W-1:0]           r_rep, w_rep_nxt;
`endif

   assign w_last_dwell = r_scan_en && (r_div == DIV_LAST);

   // r_scan_en holds the counters for the cycle right after reset, so row 0 gets a full dwell.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_scan_en    <= 1'b0;
         r_div        <= '0;
         r_row        <= '0;
         r_snap       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_scan_en    <= 1'b1;
         r_frame_done <= 1'b0;
         if (r_scan_en) begin
            r_div <= r_div + 1'b1;
            if (w_last_dwell) begin
               r_snap[r_row] <= ~col_in;
               if (r_row == ROW_W'(ROWS - 1)) begin
                  r_row        <= '0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      row_sel = '1;
      if (r_scan_en) row_sel[r_row] = 1'b0;
   end

   always_comb begin
      w_any   = 1'b0;
      w_multi = 1'b0;
      w_key   = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r_snap[r][c]) begin
               if (w_any) w_multi = 1'b1;
               w_any = 1'b1;
               w_key = {4'(r), 4'(c)};
            end
         end
      end
   end

   assign w_single = w_any && !w_multi;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
`ifdef KEYPAD_REPEAT_EN
         r_rep   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
`ifdef KEYPAD_REPEAT_EN
         r_rep   <= w_rep_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_emit      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      w_rep_nxt   = r_rep;
`endif
      if (r_frame_done) begin
         case (r_state)
            S_IDLE: begin
               if (w_single) begin
                  w_state_nxt = S_PRESS_DB;
                  w_cnt_nxt   = CNT_W'(1);
                  w_cand_nxt  = w_key;
               end
            end
            S_PRESS_DB: begin
               if (w_single && w_key == r_cand) begin
                  if (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                     w_emit      = 1'b1;
                     w_state_nxt = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                     w_rep_nxt   = '0;
`endif
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_HELD: begin
               if (!w_any) begin
                  w_state_nxt = S_REL_DB;
                  w_cnt_nxt   = CNT_W'(1);
               end
`ifdef KEYPAD_REPEAT_EN
               else if (w_single && w_key == r_cand) begin
                  if (r_rep == REP_W'(REPEAT_FRAMES - 1)) begin
                     w_emit    = 1'b1;
                     w_rep_nxt = '0;
                  end else begin
                     w_rep_nxt = r_rep + 1'b1;
                  end
               end
`endif
            end
            S_REL_DB: begin
               if (w_any) begin
                  w_state_nxt = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                  w_rep_nxt   = '0;
`endif
               end else if (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // A simultaneous ack frees the slot, so the new code is taken instead of dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_code  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_emit) begin
         if (!r_valid || key_ack) begin
            r_code  <= r_cand;
            r_valid <= 1'b1;
            r_ovf   <= 1'b0;
         end else begin
            r_ovf <= 1'b1;
         end
      end else if (key_ack && r_valid) begin
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end
   end

   assign key_code  = {8'h00, r_code};
   assign key_valid = r_valid;
   assign overflow  = r_ovf;

endmodule
